// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-access stage: FSM states, access-size codes
// and the store-lane steering used when a request is registered onto the data bus.
package mem_access_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } ma_state_e;

  localparam logic [1:0] MemSizeB = 2'b00;
  localparam logic [1:0] MemSizeH = 2'b01;
  localparam logic [1:0] MemSizeW = 2'b10;

  // Size code 2'b11 falls into the word arm everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      MemSizeB: mis = 1'b0;
      MemSizeH: mis = lo[0];
      default:  mis = |lo;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      MemSizeB: be = 4'b0001 << lo;
      MemSizeH: be = lo[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      MemSizeB: wd = {4{data[7:0]}};
      MemSizeH: wd = {2{data[15:0]}};
      default:  wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      MemSizeB: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      MemSizeH: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one load/store on the req/gnt/rvalid data bus,
// stalls upstream while it is in flight, and returns the extended load word.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] dram_rd_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TmoLimit = 8'(TIMEOUT_CYCLES);

  ma_state_e   state_q;
  logic [7:0]  tmo_cnt_q;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [31:0] ld_ext;
  logic [7:0]  tmo_next;
  logic        tmo_hit;

  load_align u_load_align (
    .rdata_i    (bus_rdata),
    .addr_lo_i  (lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_ext)
  );

  // The count about to be reached this cycle is what gets compared to the limit.
  assign tmo_next = tmo_cnt_q + 8'd1;
  assign tmo_hit  = (tmo_next == TmoLimit);

  assign stall = mem_en & ~flush & (state_q != StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      tmo_cnt_q    <= '0;
      lo_q         <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      dram_rd_data <= '0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_en && !flush) begin
            if (is_misaligned(mem_size, addr[1:0])) begin
              misalign <= 1'b1;
              state_q  <= StDone;
            end else begin
              lo_q      <= addr[1:0];
              size_q    <= mem_size;
              uns_q     <= mem_unsigned;
              we_q      <= mem_we;
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= mem_we ? store_be(mem_size, addr[1:0]) : 4'b1111;
              bus_wdata <= mem_we ? store_wdata(mem_size, wr_data) : 32'd0;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          // Once granted the slave owes a response, so a flush must still drain it.
          if (bus_gnt) begin
            bus_req   <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= flush ? StDrain : StWait;
          end else if (flush) begin
            bus_req <= 1'b0;
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (bus_rvalid) begin
            if (flush) begin
              state_q <= StIdle;
            end else begin
              if (!we_q) dram_rd_data <= ld_ext;
              state_q <= StDone;
            end
          end else if (flush) begin
            tmo_cnt_q <= '0;
            state_q   <= StDrain;
          end else if (tmo_hit) begin
            bus_err      <= 1'b1;
            dram_rd_data <= '0;
            state_q      <= StDone;
          end else begin
            tmo_cnt_q <= tmo_next;
          end
        end
        StDrain: begin
          if (bus_rvalid || tmo_hit) begin
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_next;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
